// File: rtl/reg_read_stage_if.sv
// Decode-to-execute bus for the register-read stage: decode request, execute latch,
// two writeback ports, flush and the register peek port.
interface reg_read_stage_if #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned IdxW = $clog2(NREGS);

    logic              id_valid;
    logic              id_ready;
    logic [7:0]        id_opcode;
    logic [DATA_W-1:0] id_rip;
    logic [DATA_W-1:0] id_imm;
    logic [IdxW-1:0]   id_src1;
    logic [IdxW-1:0]   id_src2;
    logic              id_src1_valid;
    logic              id_src2_valid;
    logic [IdxW-1:0]   id_dest;
    logic [IdxW-1:0]   id_dest2;
    logic              id_dest_valid;
    logic              id_dest2_valid;

    logic              ex_valid;
    logic              ex_ready;
    logic [7:0]        ex_opcode;
    logic [DATA_W-1:0] ex_rip;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;
    logic [IdxW-1:0]   ex_dest;
    logic [IdxW-1:0]   ex_dest2;
    logic              ex_dest_valid;
    logic              ex_dest2_valid;

    logic              wb_en;
    logic              wb2_en;
    logic [IdxW-1:0]   wb_reg;
    logic [IdxW-1:0]   wb2_reg;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] wb2_data;

    logic              flush;
    logic [IdxW-1:0]   dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output id_valid, id_opcode, id_rip, id_imm, id_src1, id_src2, id_src1_valid,
               id_src2_valid, id_dest, id_dest2, id_dest_valid, id_dest2_valid,
               ex_ready, wb_en, wb2_en, wb_reg, wb2_reg, wb_data, wb2_data, flush, dbg_addr,
        input  id_ready, ex_valid, ex_opcode, ex_rip, ex_imm, ex_op1, ex_op2, ex_dest,
               ex_dest2, ex_dest_valid, ex_dest2_valid, dbg_data
    );

    modport slave (
        input  id_valid, id_opcode, id_rip, id_imm, id_src1, id_src2, id_src1_valid,
               id_src2_valid, id_dest, id_dest2, id_dest_valid, id_dest2_valid,
               ex_ready, wb_en, wb2_en, wb_reg, wb2_reg, wb_data, wb2_data, flush, dbg_addr,
        output id_ready, ex_valid, ex_opcode, ex_rip, ex_imm, ex_op1, ex_op2, ex_dest,
               ex_dest2, ex_dest_valid, ex_dest2_valid, dbg_data
    );
endinterface

// File: rtl/reg_read_stage.sv
// Operand-fetch stage: register file with busy scoreboard, RAW/WAW interlock,
// writeback bypass and a single valid/ready output latch towards execute.
module reg_read_stage #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned DATA_W = 64
) (
    input logic             clk,
    input logic             reset,
    reg_read_stage_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [NREGS-1:0]  wb_hit;

    logic              ex_valid_q, ex_valid_d;
    logic [7:0]        ex_opcode_q, ex_opcode_d;
    logic [DATA_W-1:0] ex_rip_q, ex_rip_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
    logic [DATA_W-1:0] ex_op2_q, ex_op2_d;
    logic [IdxW-1:0]   ex_dest_q, ex_dest_d;
    logic [IdxW-1:0]   ex_dest2_q, ex_dest2_d;
    logic              ex_dest_valid_q, ex_dest_valid_d;
    logic              ex_dest2_valid_q, ex_dest2_valid_d;

    logic              raw_hazard, waw_hazard, id_ready, issue;
    logic [DATA_W-1:0] op1, op2;

    always_comb begin
        wb_hit = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            wb_hit[r] = (bus.wb_en && bus.wb_reg == IdxW'(r)) ||
                        (bus.wb2_en && bus.wb2_reg == IdxW'(r));
        end
    end

    // A writeback landing this cycle resolves the hazard: it is bypassed or re-set.
    always_comb begin
        raw_hazard = (bus.id_src1_valid && busy_q[bus.id_src1] && !wb_hit[bus.id_src1]) ||
                     (bus.id_src2_valid && busy_q[bus.id_src2] && !wb_hit[bus.id_src2]);
        waw_hazard = (bus.id_dest_valid && busy_q[bus.id_dest] && !wb_hit[bus.id_dest]) ||
                     (bus.id_dest2_valid && busy_q[bus.id_dest2] && !wb_hit[bus.id_dest2]);
        id_ready   = !reset && !bus.flush && !raw_hazard && !waw_hazard &&
                     (!ex_valid_q || bus.ex_ready);
        issue      = bus.id_valid && id_ready;
    end

    always_comb begin
        op1 = '0;
        if (!bus.id_src1_valid)                              op1 = '0;
        else if (bus.wb2_en && bus.wb2_reg == bus.id_src1)   op1 = bus.wb2_data;
        else if (bus.wb_en && bus.wb_reg == bus.id_src1)     op1 = bus.wb_data;
        else                                                 op1 = regs_q[bus.id_src1];
        op2 = '0;
        if (!bus.id_src2_valid)                              op2 = '0;
        else if (bus.wb2_en && bus.wb2_reg == bus.id_src2)   op2 = bus.wb2_data;
        else if (bus.wb_en && bus.wb_reg == bus.id_src2)     op2 = bus.wb_data;
        else                                                 op2 = regs_q[bus.id_src2];
    end

    // Clear order: writebacks, then flushed entry's dests; an issuing dest set wins last.
    always_comb begin
        busy_d = busy_q & ~wb_hit;
        if (bus.flush && ex_valid_q) begin
            if (ex_dest_valid_q)  busy_d[ex_dest_q]  = 1'b0;
            if (ex_dest2_valid_q) busy_d[ex_dest2_q] = 1'b0;
        end
        if (issue) begin
            if (bus.id_dest_valid)  busy_d[bus.id_dest]  = 1'b1;
            if (bus.id_dest2_valid) busy_d[bus.id_dest2] = 1'b1;
        end
    end

    always_comb begin
        ex_valid_d       = ex_valid_q;
        ex_opcode_d      = ex_opcode_q;
        ex_rip_d         = ex_rip_q;
        ex_imm_d         = ex_imm_q;
        ex_op1_d         = ex_op1_q;
        ex_op2_d         = ex_op2_q;
        ex_dest_d        = ex_dest_q;
        ex_dest2_d       = ex_dest2_q;
        ex_dest_valid_d  = ex_dest_valid_q;
        ex_dest2_valid_d = ex_dest2_valid_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (issue) begin
            ex_valid_d       = 1'b1;
            ex_opcode_d      = bus.id_opcode;
            ex_rip_d         = bus.id_rip;
            ex_imm_d         = bus.id_imm;
            ex_op1_d         = op1;
            ex_op2_d         = op2;
            ex_dest_d        = bus.id_dest;
            ex_dest2_d       = bus.id_dest2;
            ex_dest_valid_d  = bus.id_dest_valid;
            ex_dest2_valid_d = bus.id_dest2_valid;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            if (bus.wb_en)  regs_q[bus.wb_reg]  <= bus.wb_data;
            if (bus.wb2_en) regs_q[bus.wb2_reg] <= bus.wb2_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q           <= '0;
            ex_valid_q       <= 1'b0;
            ex_opcode_q      <= '0;
            ex_rip_q         <= '0;
            ex_imm_q         <= '0;
            ex_op1_q         <= '0;
            ex_op2_q         <= '0;
            ex_dest_q        <= '0;
            ex_dest2_q       <= '0;
            ex_dest_valid_q  <= 1'b0;
            ex_dest2_valid_q <= 1'b0;
        end else begin
            busy_q           <= busy_d;
            ex_valid_q       <= ex_valid_d;
            ex_opcode_q      <= ex_opcode_d;
            ex_rip_q         <= ex_rip_d;
            ex_imm_q         <= ex_imm_d;
            ex_op1_q         <= ex_op1_d;
            ex_op2_q         <= ex_op2_d;
            ex_dest_q        <= ex_dest_d;
            ex_dest2_q       <= ex_dest2_d;
            ex_dest_valid_q  <= ex_dest_valid_d;
            ex_dest2_valid_q <= ex_dest2_valid_d;
        end
    end

    assign bus.id_ready       = id_ready;
    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_opcode      = ex_opcode_q;
    assign bus.ex_rip         = ex_rip_q;
    assign bus.ex_imm         = ex_imm_q;
    assign bus.ex_op1         = ex_op1_q;
    assign bus.ex_op2         = ex_op2_q;
    assign bus.ex_dest        = ex_dest_q;
    assign bus.ex_dest2       = ex_dest2_q;
    assign bus.ex_dest_valid  = ex_dest_valid_q;
    assign bus.ex_dest2_valid = ex_dest2_valid_q;
    assign bus.dbg_data       = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_reg_read_stage.sv
// Directed scenarios plus randomized traffic for reg_read_stage, checked against an
// instruction-level reference model of the register file, scoreboard and output latch.
module tb_reg_read_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_read_stage_if #(.NREGS(16), .DATA_W(64)) bus ();

    reg_read_stage #(.NREGS(16), .DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0] m_regs [16];
    bit          m_busy [16];
    bit          m_exv;
    bit          m_known;
    logic [7:0]  m_opc;
    logic [63:0] m_rip, m_imm, m_op1, m_op2;
    logic [3:0]  m_d, m_d2;
    bit          m_dv, m_d2v;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_hit(input logic [3:0] s);
        return (bus.wb_en && bus.wb_reg == s) || (bus.wb2_en && bus.wb2_reg == s);
    endfunction

    function automatic bit m_ready();
        if (reset || bus.flush) return 1'b0;
        if (bus.id_src1_valid && m_busy[bus.id_src1] && !m_hit(bus.id_src1)) return 1'b0;
        if (bus.id_src2_valid && m_busy[bus.id_src2] && !m_hit(bus.id_src2)) return 1'b0;
        if (bus.id_dest_valid && m_busy[bus.id_dest] && !m_hit(bus.id_dest)) return 1'b0;
        if (bus.id_dest2_valid && m_busy[bus.id_dest2] && !m_hit(bus.id_dest2)) return 1'b0;
        return !m_exv || bus.ex_ready;
    endfunction

    // Value an instruction would read for a source right now.
    function automatic logic [63:0] m_read(input bit v, input logic [3:0] s);
        if (!v) return 64'h0;
        if (bus.wb2_en && bus.wb2_reg == s) return bus.wb2_data;
        if (bus.wb_en && bus.wb_reg == s) return bus.wb_data;
        return m_regs[s];
    endfunction

    task automatic model_update();
        bit issue;
        logic [63:0] a, b;
        if (reset) begin
            for (int r = 0; r < 16; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
            m_exv = 0; m_known = 1; m_opc = '0; m_rip = '0; m_imm = '0; m_op1 = '0;
            m_op2 = '0; m_d = '0; m_d2 = '0; m_dv = 0; m_d2v = 0;
            return;
        end
        issue = bus.id_valid && m_ready();
        a = m_read(bus.id_src1_valid, bus.id_src1);
        b = m_read(bus.id_src2_valid, bus.id_src2);
        if (bus.wb_en)  begin m_regs[bus.wb_reg] = bus.wb_data;   m_busy[bus.wb_reg] = 0;  end
        if (bus.wb2_en) begin m_regs[bus.wb2_reg] = bus.wb2_data; m_busy[bus.wb2_reg] = 0; end
        if (bus.flush) begin
            if (m_exv && m_dv)  m_busy[m_d] = 0;
            if (m_exv && m_d2v) m_busy[m_d2] = 0;
            m_exv = 0;
        end else if (issue) begin
            if (bus.id_dest_valid)  m_busy[bus.id_dest] = 1;
            if (bus.id_dest2_valid) m_busy[bus.id_dest2] = 1;
            m_exv = 1; m_known = 1; m_opc = bus.id_opcode; m_rip = bus.id_rip;
            m_imm = bus.id_imm; m_op1 = a; m_op2 = b; m_d = bus.id_dest; m_d2 = bus.id_dest2;
            m_dv = bus.id_dest_valid; m_d2v = bus.id_dest2_valid;
        end else if (bus.ex_ready) begin
            m_exv = 0;
        end
    endtask

    // One clock: check id_ready before the edge, outputs after; returns at the negedge.
    task automatic step();
        #1;
        check_eq("id_ready", bus.id_ready, m_ready());
        model_update();
        @(posedge clk);
        #1;
        check_eq("ex_valid", bus.ex_valid, m_exv);
        if (m_exv || m_known) begin
            check_eq("ex_opcode", bus.ex_opcode, m_opc);
            check_eq("ex_rip", bus.ex_rip, m_rip);
            check_eq("ex_imm", bus.ex_imm, m_imm);
            check_eq("ex_op1", bus.ex_op1, m_op1);
            check_eq("ex_op2", bus.ex_op2, m_op2);
            check_eq("ex_dest", {bus.ex_dest2_valid, bus.ex_dest_valid, bus.ex_dest2, bus.ex_dest},
                     {m_d2v, m_dv, m_d2, m_d});
        end
        if (m_exv) m_known = 0;
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.id_valid = 0; bus.id_opcode = '0; bus.id_rip = '0; bus.id_imm = '0;
        bus.id_src1 = '0; bus.id_src2 = '0; bus.id_src1_valid = 0; bus.id_src2_valid = 0;
        bus.id_dest = '0; bus.id_dest2 = '0; bus.id_dest_valid = 0; bus.id_dest2_valid = 0;
        bus.ex_ready = 1; bus.wb_en = 0; bus.wb2_en = 0; bus.wb_reg = '0; bus.wb2_reg = '0;
        bus.wb_data = '0; bus.wb2_data = '0; bus.flush = 0;
    endtask

    task automatic present(input logic [7:0] op, input logic [3:0] s1, input bit s1v,
                           input logic [3:0] s2, input bit s2v, input logic [3:0] d,
                           input bit dv, input logic [3:0] d2, input bit d2v);
        bus.id_valid = 1; bus.id_opcode = op; bus.id_rip = 64'h1000 + 64'(op);
        bus.id_imm = 64'hFFFF_FFFF_FFFF_FF00 | 64'(op);
        bus.id_src1 = s1; bus.id_src1_valid = s1v; bus.id_src2 = s2; bus.id_src2_valid = s2v;
        bus.id_dest = d; bus.id_dest_valid = dv; bus.id_dest2 = d2; bus.id_dest2_valid = d2v;
    endtask

    initial begin
        set_idle();
        bus.dbg_addr = '0;
        reset = 1;
        step();
        step();
        check_eq("reset_ex_valid", bus.ex_valid, 0);
        check_eq("reset_ex_op1", bus.ex_op1, 0);
        check_eq("reset_ex_rip", bus.ex_rip, 0);
        for (int r = 0; r < 16; r++) begin
            bus.dbg_addr = 4'(r);
            #1 check_eq("reset_reg", bus.dbg_data, 0);
        end
        @(negedge clk);
        reset = 0;

        // First issue, both operands read as zero, dest 3 becomes busy
        present(8'h01, 4'd3, 1, 4'd5, 1, 4'd3, 1, 4'd0, 0);
        step();
        check_eq("first_valid", bus.ex_valid, 1);
        check_eq("first_op1", bus.ex_op1, 0);
        check_eq("first_op2", bus.ex_op2, 0);
        set_idle();
        bus.id_src1 = 4'd3; bus.id_src1_valid = 1;
        #1 check_eq("busy3_stall", bus.id_ready, 0);
        step();

        set_idle();
        bus.wb_en = 1; bus.wb_reg = 4'd3; bus.wb_data = 64'h1234;
        step();
        set_idle();
        step();
        present(8'h02, 4'd3, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        step();
        check_eq("wb_read_op1", bus.ex_op1, 64'h1234);

        // RAW stall, then bypass from a same-cycle writeback
        set_idle();
        present(8'h03, 4'd0, 0, 4'd0, 0, 4'd2, 1, 4'd0, 0);
        step();
        present(8'h04, 4'd2, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        #1 check_eq("raw_stall", bus.id_ready, 0);
        step();
        bus.wb_en = 1; bus.wb_reg = 4'd2; bus.wb_data = 64'hAA;
        #1 check_eq("raw_release", bus.id_ready, 1);
        step();
        check_eq("raw_bypass_op1", bus.ex_op1, 64'hAA);

        // WAW stall, release on writeback, new writer keeps reg busy
        set_idle();
        present(8'h05, 4'd0, 0, 4'd0, 0, 4'd7, 1, 4'd0, 0);
        step();
        present(8'h06, 4'd0, 0, 4'd0, 0, 4'd7, 1, 4'd0, 0);
        #1 check_eq("waw_stall", bus.id_ready, 0);
        step();
        bus.wb_en = 1; bus.wb_reg = 4'd7; bus.wb_data = 64'h77;
        #1 check_eq("waw_release", bus.id_ready, 1);
        step();
        set_idle();
        present(8'h07, 4'd7, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        #1 check_eq("waw_busy_kept", bus.id_ready, 0);
        step();
        set_idle();
        bus.wb_en = 1; bus.wb_reg = 4'd7; bus.wb_data = 64'h78;
        step();

        // Backpressure holds the latch and blocks issue
        set_idle();
        present(8'h10, 4'd1, 1, 4'd2, 1, 4'd0, 0, 4'd0, 0);
        step();
        present(8'h11, 4'd3, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        bus.ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("bp_no_ready", bus.id_ready, 0);
            step();
            check_eq("bp_hold_opcode", bus.ex_opcode, 8'h10);
        end
        bus.ex_ready = 1;
        step();
        check_eq("bp_next_opcode", bus.ex_opcode, 8'h11);

        // Flush drops the entry and its dests; dual writeback to one reg
        set_idle();
        present(8'h20, 4'd0, 0, 4'd0, 0, 4'd9, 1, 4'd2, 1);
        step();
        set_idle();
        bus.ex_ready = 0; bus.flush = 1;
        step();
        check_eq("flush_valid", bus.ex_valid, 0);
        set_idle();
        present(8'h21, 4'd9, 1, 4'd2, 1, 4'd0, 0, 4'd0, 0);
        #1 check_eq("flush_busy_clear", bus.id_ready, 1);
        step();
        set_idle();
        bus.wb_en = 1; bus.wb_reg = 4'd1; bus.wb_data = 64'h11;
        bus.wb2_en = 1; bus.wb2_reg = 4'd1; bus.wb2_data = 64'h22;
        step();
        set_idle();
        bus.dbg_addr = 4'd1;
        #1 check_eq("wb2_wins", bus.dbg_data, 64'h22);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(199) == 0);
            bus.flush = ($urandom_range(24) == 0);
            bus.id_valid = ($urandom_range(9) < 7);
            bus.ex_ready = ($urandom_range(3) != 0);
            bus.id_opcode = 8'($urandom);
            bus.id_rip = {$urandom, $urandom};
            bus.id_imm = {$urandom, $urandom};
            bus.id_src1 = 4'($urandom_range(7)); bus.id_src1_valid = ($urandom_range(4) != 0);
            bus.id_src2 = 4'($urandom_range(7)); bus.id_src2_valid = ($urandom_range(4) != 0);
            bus.id_dest = 4'($urandom_range(7)); bus.id_dest_valid = ($urandom_range(9) < 6);
            bus.id_dest2 = 4'($urandom_range(7)); bus.id_dest2_valid = ($urandom_range(6) == 0);
            bus.wb_en = ($urandom_range(9) < 4); bus.wb_reg = 4'($urandom_range(7));
            bus.wb_data = {$urandom, $urandom};
            bus.wb2_en = ($urandom_range(4) == 0); bus.wb2_reg = 4'($urandom_range(7));
            bus.wb2_data = {$urandom, $urandom};
            step();
        end
        reset = 0;
        set_idle();
        for (int r = 0; r < 16; r++) begin
            bus.dbg_addr = 4'(r);
            #1 check_eq("final_reg", bus.dbg_data, m_regs[r]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
